mem_responder: RTL and testbench

Memory-side responder for the CPU's load/store and instruction-fetch port. It accepts one word request at a time over a valid/ready handshake, waits a configurable number of wait states, and then commits writes or returns read data from an internal word RAM. The response is held until the requester accepts it. The block sits at the far end of the CPU memory interface and replaces the zero-latency combinational memory model with a handshaked, latency-bearing target.

---
 rtl/mem_responder_pkg.sv | 7 +
 rtl/mem_responder_ram.sv | 25 ++
 rtl/mem_responder.sv | 98 +++++++++
 tb/tb_mem_responder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and widths for the handshaked memory responder.
package mem_responder_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam int CNT_W  = 4;
  localparam int WORD_W = 32;
  localparam int BE_W   = WORD_W / 8;
endpackage

// File: rtl/mem_responder_ram.sv
// Single-port word RAM: byte-enabled synchronous write, combinational read, no reset.
module mem_responder_ram
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wd,
  output logic [WORD_W-1:0] rd
);
  logic [BE_W-1:0][7:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_W; b++)
        if (be[b]) mem[addr][b] <= wd[8*b +: 8];
    end
  end

  assign rd = mem[addr];
endmodule

// File: rtl/mem_responder.sv
// Handshaked, wait-state memory target. Define MEM_RESPONDER_ALIGN_CHECK_EN to
// flag byte addresses with nonzero low bits as errors.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [WORD_W-1:0] req_wd,
  input  logic [BE_W-1:0]   req_be,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic                lat_we;
  logic [31:0]         lat_addr;
  logic [WORD_W-1:0]   lat_wd;
  logic [BE_W-1:0]     lat_be;
  logic [31:0]         offset;
  logic                in_range, addr_ok, commit, ram_we;
  logic [WORD_W-1:0]   ram_rd;

  // Unsigned wrap makes addresses below BASE_ADDR land far out of range.
  assign offset   = lat_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
  assign addr_ok  = in_range && (lat_addr[1:0] == 2'b00);
`else
  assign addr_ok  = in_range;
`endif
  assign commit    = (state == ACCESS) && (cnt == '0);
  assign ram_we    = commit && lat_we && addr_ok;
  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  mem_responder_ram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .be   (lat_be),
    .addr (offset[AW+1:2]),
    .wd   (lat_wd),
    .rd   (ram_rd)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = ACCESS;
      ACCESS:  if (cnt == '0) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wd    <= '0;
      lat_be    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        lat_we   <= req_we;
        lat_addr <= req_addr;
        lat_wd   <= req_wd;
        lat_be   <= req_be;
        cnt      <= CNT_W'(WAIT_STATES);
      end else if (state == ACCESS && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (commit) begin
        rsp_rdata <= (!lat_we && addr_ok) ? ram_rd : '0;
        rsp_err   <= !addr_ok;
      end else if (rsp_valid && rsp_ready) begin
        rsp_rdata <= '0;
        rsp_err   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a word-array reference model.
module tb_mem_responder;
  localparam int          DEPTH = 1024;
  localparam int          WS    = 1;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          NINIT = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wd = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0, failures = 0;
  logic [31:0] model [DEPTH];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wd(req_wd), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference: expected error flag and read data; applies writes to the model.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, output logic err, output logic [31:0] rd);
    logic [31:0] off;
    int idx;
    off = addr - BASE;
    err = !(off < DEPTH * 4);
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) err = 1'b1;
`endif
    idx = int'(off / 4);
    rd = '0;
    if (!err) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) model[idx][8*b +: 8] = wd[8*b +: 8];
      end else rd = model[idx];
    end
  endtask

  // One full transaction; hold = cycles of response backpressure.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input int hold, input string tag);
    logic exp_err;
    logic [31:0] exp_rd;
    int lat;
    model_access(we, addr, wd, be, exp_err, exp_rd);
    @(negedge clk);
    chk({tag, ".req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wd = wd; req_be = be;
    @(posedge clk); #1;
    // Scramble request fields after the accept edge: they must be ignored.
    req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wd = $urandom; req_be = 4'($urandom);
    lat = 0;
    do begin
      @(negedge clk); lat++;
      if (!rsp_valid && req_ready) begin
        chk({tag, ".early_ready"}, 32'(req_ready), 32'd0);
        break;
      end
    end while (!rsp_valid && lat < 50);
    chk({tag, ".latency"}, 32'(lat), 32'(WS + 2));
    if (!rsp_valid) return;
    chk({tag, ".rdata"}, rsp_rdata, exp_rd);
    chk({tag, ".err"}, 32'(rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata, exp_rd);
      chk({tag, ".hold_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".post_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, ".post_rdata"}, rsp_rdata, 32'd0);
    chk({tag, ".post_err"}, 32'(rsp_err), 32'd0);
    chk({tag, ".post_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); rstn = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.req_ready", 32'(req_ready), 32'd1);
    chk("rst.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst.rsp_rdata", rsp_rdata, 32'd0);
    chk("rst.rsp_err", 32'(rsp_err), 32'd0);
    rstn = 1'b1;
  endtask

  initial begin
    logic e;
    logic [31:0] d;
    do_reset();
    for (int i = 0; i < NINIT; i++)
      xact(1'b1, BASE + 32'(i * 4), 32'h1000_0000 + 32'(i), 4'hF, 0, "init");

    xact(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, "wr10");
    xact(1'b0, BASE + 32'h10, 32'h0, 4'h0, 0, "rd10");
    xact(1'b1, BASE + 32'h10, 32'h0000_1200, 4'b0010, 0, "pwr10");
    chk("model.partial", model[4], 32'hDEAD_12EF);
    xact(1'b0, BASE + 32'h10, 32'h0, 4'h0, 5, "bp_rd10");
    xact(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'h0, 0, "be0");
    xact(1'b1, BASE + 32'h1000, 32'hCAFE_F00D, 4'hF, 0, "oor_wr");
    xact(1'b0, BASE + 32'h0, 32'h0, 4'h0, 0, "rd0");
    xact(1'b0, BASE + 32'h12, 32'h0, 4'h0, 0, "mis_rd");
    xact(1'b0, BASE - 32'h4, 32'h0, 4'h0, 0, "below_base");

    // Reset in ACCESS before the commit edge: write must be lost.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h14; req_wd = 32'h5555_AAAA; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0; rstn = 1'b0;
    do_reset();
    xact(1'b0, BASE + 32'h14, 32'h0, 4'h0, 0, "abort_rd");

    // Reset in RESP: committed write persists.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = BASE + 32'h18; req_wd = 32'h1234_5678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (WS + 2) @(negedge clk);
    chk("resp_rst.valid", 32'(rsp_valid), 32'd1);
    model_access(1'b1, BASE + 32'h18, 32'h1234_5678, 4'hF, e, d);
    do_reset();
    xact(1'b0, BASE + 32'h18, 32'h0, 4'h0, 0, "persist_rd");

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? BASE + 32'h1000 + 32'($urandom_range(0, 4095))
                                      : BASE + 32'($urandom_range(0, NINIT * 4 - 1));
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
